// File: rtl/pipelined_data_memory.sv
// ---------------------------------------------------------------------------
// pipelined_data_memory
//
// Data memory for the MEM stage of the MIPS pipeline. Accepts one request
// per cycle over a valid/ready handshake. Loads return in order after a
// fixed RD_LATENCY. Stores commit in a single cycle and produce no response.
//
// Ports:
//   clk         rising-edge clock
//   Reset       asynchronous active-low reset
//   req_valid   request present
//   req_ready   request accepted this cycle when req_valid is also high
//   req_write   1 = store, 0 = load
//   req_addr    byte address (upper bits alias modulo DEPTH words)
//   req_wdata   store data
//   req_be      store byte-lane enables, bit i selects byte i
//   flush       kill every in-flight load
//   resp_valid  load data valid (final pipeline stage)
//   resp_ready  consumer accepts the response
//   resp_rdata  load data, 0 when resp_valid is low or the load was misaligned
//   resp_err    load was misaligned
//   ld_count    accepted loads, wrapping
//   st_count    committed stores, wrapping
// ---------------------------------------------------------------------------
module pipelined_data_memory #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH      = 256,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       RD_LATENCY = 2,
    parameter logic [DATA_W-1:0] INIT_VAL   = DATA_W'(5)
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic                flush,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [15:0]         ld_count,
    output logic [15:0]         st_count
);

    localparam int unsigned NUM_BE = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned LSB_W  = $clog2(NUM_BE);
    // Byte-offset bits inside a word; zero-width offset gives an empty mask.
    localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((64'd1 << LSB_W) - 64'd1);

    logic [DATA_W-1:0]     mem_q  [DEPTH];
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] err_q;
    logic [DATA_W-1:0]     data_q [RD_LATENCY];
    logic [15:0]           ld_count_q;
    logic [15:0]           st_count_q;

    logic             stall;
    logic             accept;
    logic             misaligned;
    logic             ld_accept;
    logic             st_commit;
    logic [IDX_W-1:0] word_idx;

    always_comb begin
        stall      = vld_q[RD_LATENCY-1] & ~resp_ready;
        req_ready  = ~stall & ~flush;
        accept     = req_valid & req_ready;
        misaligned = |(req_addr & LSB_MASK);
        word_idx   = IDX_W'(req_addr >> LSB_W);
        ld_accept  = accept & ~req_write;
        st_commit  = accept & req_write & ~misaligned;
    end

    // Storage array; a misaligned store leaves it untouched.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= INIT_VAL;
            end
        end else if (st_commit) begin
            for (int b = 0; b < int'(NUM_BE); b++) begin
                if (req_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline. Stage 0 samples the array at the accepting edge, so a
    // store committed on an earlier edge is visible and later ones are not.
    // Flush clears valid bits even while stalled.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                data_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q[0]  <= ld_accept;
            err_q[0]  <= misaligned;
            data_q[0] <= misaligned ? '0 : mem_q[word_idx];
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            ld_count_q <= '0;
            st_count_q <= '0;
        end else begin
            if (ld_accept) ld_count_q <= ld_count_q + 16'd1;
            if (st_commit) st_count_q <= st_count_q + 16'd1;
        end
    end

    assign resp_valid = vld_q[RD_LATENCY-1];
    assign resp_rdata = vld_q[RD_LATENCY-1] ? data_q[RD_LATENCY-1] : '0;
    assign resp_err   = vld_q[RD_LATENCY-1] & err_q[RD_LATENCY-1];
    assign ld_count   = ld_count_q;
    assign st_count   = st_count_q;

endmodule
